// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: debug-word inputs, step button and 7-segment outputs of seg_scan_display
interface seg_scan_display_if;
   logic [1:0] sel;
   logic [15:0] sign1;
   logic [15:0] sign2;
   logic [15:0] sign3;
   logic [15:0] sign4;
   logic dp_in;
   logic btn_raw;
   logic [3:0] an;
   logic [7:0] seg;
   logic btn_level;
   logic step_pulse;
   modport master (
      output sel, sign1, sign2, sign3, sign4, dp_in, btn_raw,
      input an, seg, btn_level, step_pulse
   );
   modport slave (
      input sel, sign1, sign2, sign3, sign4, dp_in, btn_raw,
      output an, seg, btn_level, step_pulse
   );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display: 4-digit hex scan of a selected debug word plus step-button debouncer.
// Optional SEG_DP_REGWRE_EN lights the dot on digit 2 from the RegWre bit captured at frame start.
module seg_scan_display #(
   parameter int CLK_DIV = 50000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input logic CLK,
   input logic Reset,
   seg_scan_display_if.slave bus
);
   localparam int SW = $clog2(CLK_DIV);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [SW-1:0] S_LAST = SW'(CLK_DIV - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   logic [SW-1:0] scan;
   logic [1:0] idx;
   logic [15:0] shadow;
   logic tick, wrap, dp_n;
   logic [1:0] idx_n;
   logic [15:0] word, shadow_n;
   logic [3:0] nib;

   // seg/an are computed from the post-edge index and shadow so both change together
   always_comb begin
      tick = scan == S_LAST;
      wrap = tick && idx == 2'd3;
      idx_n = idx + 2'd1;
      word = bus.sel == 2'd0 ? bus.sign1 : bus.sel == 2'd1 ? bus.sign2 :
             bus.sel == 2'd2 ? bus.sign3 : bus.sign4;
      shadow_n = wrap ? word : shadow;
      nib = shadow_n[{idx_n, 2'b00} +: 4];
   end

`ifdef SEG_DP_REGWRE_EN
   logic shadow_dp;
   always_comb dp_n = ~((wrap ? bus.dp_in : shadow_dp) && idx_n == 2'd2);
   always_ff @(posedge CLK or posedge Reset)
      if (Reset) shadow_dp <= 1'b0;
      else if (wrap) shadow_dp <= bus.dp_in;
`else
   always_comb dp_n = 1'b1;
`endif

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         scan <= '0;
         idx <= 2'd0;
         shadow <= 16'h0000;
         bus.an <= 4'b1110;
         bus.seg <= 8'hC0;
      end else begin
         scan <= tick ? '0 : scan + 1'b1;
         if (tick) begin
            idx <= idx_n;
            shadow <= shadow_n;
            bus.an <= ~(4'b0001 << idx_n);
            bus.seg <= {dp_n, hex7(nib)};
         end
      end
   end

   logic s0, s1, db_hit;
   logic [DW-1:0] dcnt;

   always_comb db_hit = s1 != bus.btn_level && dcnt == D_LAST;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         s0 <= 1'b0;
         s1 <= 1'b0;
         dcnt <= '0;
         bus.btn_level <= 1'b0;
         bus.step_pulse <= 1'b0;
      end else begin
         s0 <= bus.btn_raw;
         s1 <= s0;
         dcnt <= (s1 == bus.btn_level || db_hit) ? '0 : dcnt + 1'b1;
         if (db_hit) bus.btn_level <= s1;
         bus.step_pulse <= db_hit && s1;
      end
   end
endmodule
